binary_up_down_counter: RTL and testbench

//   Synchronous, loadable binary up/down counter with count enable and async reset.

---
 rtl/binary_up_down_counter_if.sv | 27 ++
 rtl/binary_up_down_counter.sv | 44 ++++
 tb/tb_binary_up_down_counter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/binary_up_down_counter_if.sv
// Control and count bus for the loadable up/down counter.
// The master drives load/enable/direction; the slave returns the count.
interface binary_up_down_counter_if #(
  parameter int WIDTH = 4
);
  logic             Load;
  logic             Count_en;
  logic             Up;
  logic [WIDTH-1:0] Count_in;
  logic [WIDTH-1:0] Count_out;

  modport master (
    output Load,
    output Count_en,
    output Up,
    output Count_in,
    input  Count_out
  );

  modport slave (
    input  Load,
    input  Count_en,
    input  Up,
    input  Count_in,
    output Count_out
  );
endinterface

// File: rtl/binary_up_down_counter.sv
// Loadable modulo-2^WIDTH up/down counter with enable.
// Async active-low clear; Count_out comes straight from the register.
module binary_up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    nReset,
  binary_up_down_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic             do_load;
  logic             do_inc;
  logic             do_dec;

  // Load outranks counting, so the terms are made mutually exclusive.
  assign do_load = bus.Load;
  assign do_inc  = !bus.Load && bus.Count_en && bus.Up;
  assign do_dec  = !bus.Load && bus.Count_en && !bus.Up;

  always_comb begin
    count_next = count;
    unique case (1'b1)
      do_load: count_next = bus.Count_in;
      do_inc:  count_next = count + ONE;
      do_dec:  count_next = count - ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign bus.Count_out = count;

endmodule

// File: tb/tb_binary_up_down_counter.sv
// Scoreboard bench for binary_up_down_counter.
// Stimulus pushes hand-computed counts; a monitor pops and compares.
module tb_binary_up_down_counter;

  logic clk;
  logic nReset;

  binary_up_down_counter_if #(.WIDTH(4)) bus ();

  binary_up_down_counter #(.WIDTH(4)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] exp;
    int         id;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   checks;
  int   failures;
  int   next_id;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one sample per rising edge (or async probe) while work is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.Count_out !== e.exp) begin
          failures++;
          $display("FAIL count_out#%0d got=%0d exp=%0d",
                   e.id, bus.Count_out, e.exp);
        end
      end
    end
  end

  task automatic push(input logic [3:0] exp);
    exp_t e;
    e.exp = exp;
    e.id  = next_id;
    next_id++;
    sb.push_back(e);
  endtask

  // One clocked vector: drive at negedge, expect result after next posedge.
  task automatic step(input logic rn, input logic ld, input logic en,
                      input logic up, input logic [3:0] cin,
                      input logic [3:0] exp);
    @(negedge clk);
    nReset       = rn;
    bus.Load     = ld;
    bus.Count_en = en;
    bus.Up       = up;
    bus.Count_in = cin;
    push(exp);
  endtask

  // Drop reset between edges and probe the output before any clock.
  task automatic async_reset();
    @(negedge clk);
    nReset = 1'b0;
    #1;
    push(4'd0);
    ->sample_ev;
    #2;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    next_id      = 0;
    nReset       = 1'b0;
    bus.Load     = 1'b1;
    bus.Count_en = 1'b0;
    bus.Up       = 1'b1;
    bus.Count_in = 4'd12;
    #1;
    push(4'd0);
    ->sample_ev;
    #2;

    step(0, 1, 0, 1, 12, 0);
    step(0, 1, 1, 1, 12, 0);

    step(1, 0, 1, 1, 0, 1);
    step(1, 0, 1, 1, 0, 2);
    step(1, 0, 1, 1, 0, 3);
    step(1, 0, 1, 1, 0, 4);
    step(1, 0, 1, 1, 0, 5);

    step(1, 1, 0, 1, 12, 12);
    step(1, 0, 1, 1, 0, 13);
    step(1, 0, 1, 1, 0, 14);
    step(1, 0, 1, 1, 0, 15);
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 1);

    async_reset();
    step(0, 0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 4, 4);
    step(1, 0, 1, 0, 0, 3);
    step(1, 0, 1, 0, 0, 2);
    step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 15);

    step(1, 0, 0, 1, 0, 15);
    step(1, 0, 0, 0, 0, 15);
    step(1, 0, 0, 1, 0, 15);
    step(1, 1, 0, 0, 6, 6);
    step(1, 0, 0, 1, 3, 6);

    step(1, 1, 1, 1, 9, 9);
    step(1, 0, 1, 0, 0, 8);
    step(1, 0, 1, 1, 0, 9);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
